// File: rtl/neuron_potential_sequencer_if.sv
// Signal bundle between the neuron potential sequencer, its adder, the weight
// source and the spike router. The master modport is the sequencer side.
interface neuron_potential_sequencer_if;
  logic        timestep_start;
  logic        weight_valid;
  logic        weight_ready;
  logic [31:0] weight_data;
  logic        set_adder;
  logic        clear_adder;
  logic [31:0] input_weight;
  logic [31:0] decayed_potential;
  logic [31:0] final_potential;
  logic        spike_in;
  logic        spike_valid;
  logic        spike_ready;
  logic [31:0] potential;
  logic        busy;
  logic        done;
  logic [7:0]  overrun_count;

  modport master (
    input  timestep_start, weight_valid, weight_data, final_potential, spike_in, spike_ready,
    output weight_ready, set_adder, clear_adder, input_weight, decayed_potential,
           spike_valid, potential, busy, done, overrun_count
  );

  modport slave (
    output timestep_start, weight_valid, weight_data, final_potential, spike_in, spike_ready,
    input  weight_ready, set_adder, clear_adder, input_weight, decayed_potential,
           spike_valid, potential, busy, done, overrun_count
  );
endinterface

// File: rtl/neuron_potential_sequencer.sv
// Per-neuron timestep controller: holds the FP32 membrane potential, applies
// decay, sequences the external potential adder and forwards spikes.
module neuron_potential_sequencer #(
  parameter logic [31:0] V_INIT        = 32'h0000_0000,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter bit          DECAY_EN      = 1'b1
) (
  input logic                          CLK,
  input logic                          RST_N,
  neuron_potential_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_WAIT_W  = 3'd2,
    ST_DECAY   = 3'd3,
    ST_APPLY   = 3'd4,
    ST_CAPTURE = 3'd5,
    ST_EMIT    = 3'd6,
    ST_CLEAR   = 3'd7
  } state_t;

  localparam logic [3:0] LP_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_potential;
  logic [31:0] r_decayed;
  logic [31:0] r_weight;
  logic [3:0]  r_settle;
  logic        r_spike_valid;
  logic [7:0]  r_overrun;
  logic        w_weight_ready;
  logic        w_busy;
  logic        w_set_adder;
  logic        w_clear_adder;
  logic        w_done;

  // Halving by exponent decrement; tiny values flush to +0, Inf/NaN pass through.
  function automatic logic [31:0] f_decay(input logic [31:0] v);
    logic [31:0] res;
    if (!DECAY_EN) begin
      res = v;
    end else if ((v[30:23] == 8'd0) || (v[30:23] == 8'd1)) begin
      res = 32'h0000_0000;
    end else if (v[30:23] == 8'hFF) begin
      res = v;
    end else begin
      res = {v[31], v[30:23] - 8'd1, v[22:0]};
    end
    return res;
  endfunction

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and state-decoded controls
  always_comb begin
    w_next         = r_state;
    w_weight_ready = 1'b0;
    w_busy         = 1'b1;
    w_set_adder    = 1'b0;
    w_clear_adder  = 1'b0;
    w_done         = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_set_adder = 1'b1;
        w_next      = ST_IDLE;
      end
      ST_IDLE: begin
        w_busy = 1'b0;
        if (bus.timestep_start) w_next = ST_WAIT_W;
        else                    w_next = ST_IDLE;
      end
      ST_WAIT_W: begin
        w_weight_ready = 1'b1;
        if (bus.weight_valid) w_next = ST_DECAY;
        else                  w_next = ST_WAIT_W;
      end
      ST_DECAY: w_next = ST_APPLY;
      ST_APPLY: begin
        if (r_settle == LP_SETTLE_LAST) w_next = ST_CAPTURE;
        else                            w_next = ST_APPLY;
      end
      ST_CAPTURE: begin
        if (bus.spike_in) w_next = ST_EMIT;
        else              w_next = ST_CLEAR;
      end
      ST_EMIT: begin
        if (bus.spike_ready) w_next = ST_CLEAR;
        else                 w_next = ST_EMIT;
      end
      ST_CLEAR: begin
        w_clear_adder = 1'b1;
        w_done        = 1'b1;
        w_next        = ST_IDLE;
      end
      default: w_next = ST_INIT;
    endcase
  end

  // Datapath registers: weight, decayed operand, potential, spike flag, counters
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_potential   <= V_INIT;
      r_decayed     <= 32'h0000_0000;
      r_weight      <= 32'h0000_0000;
      r_settle      <= 4'd0;
      r_spike_valid <= 1'b0;
      r_overrun     <= 8'd0;
    end else begin
      if ((r_state == ST_WAIT_W) && bus.weight_valid) r_weight <= bus.weight_data;
      if (r_state == ST_DECAY) begin
        r_decayed <= f_decay(r_potential);
        r_settle  <= 4'd0;
      end else if (r_state == ST_APPLY) begin
        r_settle <= r_settle + 4'd1;
      end
      if (r_state == ST_CAPTURE) begin
        r_potential   <= bus.final_potential;
        r_spike_valid <= bus.spike_in;
      end else if ((r_state == ST_EMIT) && bus.spike_ready) begin
        r_spike_valid <= 1'b0;
      end
      // A start pulse outside IDLE never begins a timestep; it is only counted.
      if (bus.timestep_start && (r_state != ST_IDLE) && (r_overrun != 8'hFF)) begin
        r_overrun <= r_overrun + 8'd1;
      end
    end
  end

  assign bus.weight_ready      = w_weight_ready;
  assign bus.busy              = w_busy;
  assign bus.set_adder         = w_set_adder;
  assign bus.clear_adder       = w_clear_adder;
  assign bus.done              = w_done;
  assign bus.input_weight      = r_weight;
  assign bus.decayed_potential = r_decayed;
  assign bus.potential         = r_potential;
  assign bus.spike_valid       = r_spike_valid;
  assign bus.overrun_count     = r_overrun;

endmodule

// File: tb/tb_neuron_potential_sequencer.sv
// Bench for neuron_potential_sequencer with a behavioural LIF adder (threshold
// 40.0, reset by subtraction) and a scoreboard of per-timestep results.
module tb_neuron_potential_sequencer;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  neuron_potential_sequencer_if bus ();

  neuron_potential_sequencer #(
    .V_INIT        (32'h0000_0000),
    .SETTLE_CYCLES (2),
    .DECAY_EN      (1'b1)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.master)
  );

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    logic [10:0] e;
    if (f[30:0] == 31'd0) begin
      d = {f[31], 63'd0};
    end else if (f[30:23] == 8'hFF) begin
      d = {f[31], 11'h7FF, f[22:0], 29'd0};
    end else begin
      e = {3'd0, f[30:23]} + 11'd896;
      d = {f[31], e, f[22:0], 29'd0};
    end
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    e = d[62:52];
    if (e == 11'h7FF)       return {d[63], 8'hFF, d[51:29]};
    else if (e <= 11'd896)  return 32'h0000_0000;
    else if (e >= 11'd1151) return {d[63], 8'hFF, 23'd0};
    else                    return {d[63], 8'(e - 11'd896), d[51:29]};
  endfunction

  real adder_sum;
  always_comb begin
    adder_sum    = f2r(bus.decayed_potential) + f2r(bus.input_weight);
    bus.spike_in = (adder_sum >= 40.0);
    if (adder_sum >= 40.0) bus.final_potential = r2f(adder_sum - 40.0);
    else                   bus.final_potential = r2f(adder_sum);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] pot;
    logic [31:0] dec;
    logic [31:0] w;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] w;
    logic [31:0] dec;
    logic [31:0] pot;
    logic        spk;
    int          delay;
    int          ovr_at;
    int          ovr_len;
  } vec_t;
  vec_t tbl[9];

  // Scoreboard pop on every end-of-timestep pulse
  always @(negedge CLK) begin
    exp_t e;
    if (RST_N && bus.done) begin
      if (sb.size() == 0) begin
        chk("done_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("potential", bus.potential, e.pot);
        chk("decayed_potential", bus.decayed_potential, e.dec);
        chk("input_weight", bus.input_weight, e.w);
        chk("clear_adder_at_done", {31'd0, bus.clear_adder}, 32'd1);
      end
    end
  end

  task automatic run_ts(input vec_t v);
    int c0;
    int idx;
    int vcnt;
    int lat;
    bit got;
    exp_t e;
    e.pot = v.pot;
    e.dec = v.dec;
    e.w   = v.w;
    sb.push_back(e);
    @(negedge CLK);
    bus.timestep_start = 1'b1;
    bus.weight_valid   = 1'b1;
    bus.weight_data    = v.w;
    bus.spike_ready    = (v.delay == 0);
    c0   = cyc;
    vcnt = 0;
    lat  = 0;
    got  = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge CLK);
      idx = cyc - c0;
      bus.timestep_start = (idx >= v.ovr_at) && (idx < v.ovr_at + v.ovr_len);
      if (bus.spike_valid) vcnt++;
      if (vcnt > v.delay) bus.spike_ready = 1'b1;
      if (bus.done) begin
        got = 1'b1;
        lat = idx;
      end
    end
    chk("done_seen", {31'd0, got}, 32'd1);
    if (got) begin
      chk("done_latency", lat, v.spk ? (7 + v.delay) : 6);
      chk("spike_valid_cycles", vcnt, v.spk ? (v.delay + 1) : 0);
    end
    bus.weight_valid = 1'b0;
    bus.spike_ready  = 1'b0;
    @(negedge CLK);
    bus.timestep_start = 1'b0;
    chk("idle_after_done", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    vec_t v;
    tbl[0] = '{32'h41F0_0000, 32'h0000_0000, 32'h41F0_0000, 1'b0, 0,  0, 0};
    tbl[1] = '{32'h41F0_0000, 32'h4170_0000, 32'h40A0_0000, 1'b1, 0,  0, 0};
    tbl[2] = '{32'h3F80_0000, 32'h4020_0000, 32'h4060_0000, 1'b0, 0,  0, 0};
    tbl[3] = '{32'h41F0_0000, 32'h3FE0_0000, 32'h41FE_0000, 1'b0, 0,  0, 0};
    tbl[4] = '{32'h4200_0000, 32'h417E_0000, 32'h40FC_0000, 1'b1, 10, 0, 0};
    tbl[5] = '{32'hC080_0000, 32'h407C_0000, 32'hBD80_0000, 1'b0, 0,  0, 0};
    tbl[6] = '{32'h0000_0000, 32'hBD00_0000, 32'hBD00_0000, 1'b0, 0,  0, 0};
    tbl[7] = '{32'h7F80_0000, 32'hBC80_0000, 32'h7F80_0000, 1'b1, 0,  0, 0};
    tbl[8] = '{32'h3F80_0000, 32'h7F80_0000, 32'h7F80_0000, 1'b1, 0,  0, 0};

    bus.timestep_start = 1'b0;
    bus.weight_valid   = 1'b0;
    bus.weight_data    = 32'h0000_0000;
    bus.spike_ready    = 1'b0;

    repeat (2) @(negedge CLK);
    chk("rst_set_adder", {31'd0, bus.set_adder}, 32'd1);
    chk("rst_busy", {31'd0, bus.busy}, 32'd1);
    chk("rst_potential", bus.potential, 32'h0000_0000);
    chk("rst_decayed", bus.decayed_potential, 32'h0000_0000);
    chk("rst_input_weight", bus.input_weight, 32'h0000_0000);
    chk("rst_ctrl", {27'd0, bus.weight_ready, bus.spike_valid, bus.clear_adder, bus.done, 1'b0}, 32'd0);
    chk("rst_overrun", {24'd0, bus.overrun_count}, 32'd0);

    RST_N = 1'b1;
    #1;
    chk("init_set_adder", {31'd0, bus.set_adder}, 32'd1);
    @(negedge CLK);
    chk("init_set_one_cycle", {31'd0, bus.set_adder}, 32'd0);
    chk("init_busy_fall", {31'd0, bus.busy}, 32'd0);

    for (int i = 0; i < 9; i++) run_ts(tbl[i]);
    chk("overrun_none", {24'd0, bus.overrun_count}, 32'd0);

    // Reset in the middle of APPLY
    @(negedge CLK);
    bus.timestep_start = 1'b1;
    bus.weight_valid   = 1'b1;
    bus.weight_data    = 32'h41F0_0000;
    @(negedge CLK);
    bus.timestep_start = 1'b0;
    repeat (2) @(negedge CLK);
    chk("pre_reset_busy", {31'd0, bus.busy}, 32'd1);
    RST_N = 1'b0;
    #1;
    chk("midrst_potential", bus.potential, 32'h0000_0000);
    chk("midrst_decayed", bus.decayed_potential, 32'h0000_0000);
    chk("midrst_input_weight", bus.input_weight, 32'h0000_0000);
    chk("midrst_set_adder", {31'd0, bus.set_adder}, 32'd1);
    bus.weight_valid = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    v = '{32'h0080_0000, 32'h0000_0000, 32'h0080_0000, 1'b0, 0, 0, 0};
    run_ts(v);
    v = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 0, 3, 1};
    run_ts(v);
    chk("overrun_in_apply", {24'd0, bus.overrun_count}, 32'd1);
    v = '{32'h41F0_0000, 32'h0000_0000, 32'h41F0_0000, 1'b0, 0, 6, 1};
    run_ts(v);
    chk("overrun_at_done", {24'd0, bus.overrun_count}, 32'd2);
    v = '{32'h4240_0000, 32'h4170_0000, 32'h41B8_0000, 1'b1, 300, 7, 270};
    run_ts(v);
    chk("overrun_saturate", {24'd0, bus.overrun_count}, 32'd255);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_potential_sequencer.md
# neuron_potential_sequencer

Per-neuron timestep controller that drives a `potential_adder` instance (LIF mode) from the initiator side. It holds the neuron's FP32 membrane potential and applies decay at the start of each timestep. It presents decayed potential and input weight to the adder, sequences the adder's `set`/`clear` controls, captures `final_potential`/`spike`, and forwards spikes over a valid/ready handshake to the spike router.

## Interface
Parameters:
- `V_INIT`, 32'h00000000 — FP32 potential loaded at reset.
- `SETTLE_CYCLES`, 2 — cycles operands are held before the adder result is captured; legal range 1..15.
- `DECAY_EN`, 1 — 1: halve potential each timestep; 0: no decay.

Ports:
- `CLK`  in  1  — single clock, rising edge.
- `RST_N`  in  1  — asynchronous, active-low reset.
- `timestep_start`  in  1  — one-cycle pulse that begins a timestep.
- `weight_valid`  in  1  — weight offered.
- `weight_ready`  out  1  — weight accepted when `weight_valid & weight_ready`.
- `weight_data`  in  32  — FP32 summed input weight for this timestep.
- `set_adder`  out  1  — to adder `set`; loads threshold and mode.
- `clear_adder`  out  1  — to adder `clear`.
- `input_weight`  out  32  — to adder.
- `decayed_potential`  out  32  — to adder.
- `final_potential`  in  32  — from adder.
- `spike_in`  in  1  — adder spike.
- `spike_valid`  out  1  — spike event pending.
- `spike_ready`  in  1  — downstream accepts spike.
- `potential`  out  32  — stored membrane potential.
- `busy`  out  1  — high in every state except IDLE.
- `done`  out  1  — one-cycle pulse at end of timestep.
- `overrun_count`  out  8  — saturating count of ignored `timestep_start` pulses.

## Operation
- States: INIT, IDLE, WAIT_W, DECAY, APPLY, CAPTURE, EMIT, CLEAR.
- INIT:
  - Entered on reset; lasts exactly one cycle.
  - Drives `set_adder`=1, then goes to IDLE.
  - `set_adder` is 0 in every other state.
- IDLE: `timestep_start`=1 moves to WAIT_W.
- WAIT_W:
  - `weight_ready`=1 only in this state.
  - On handshake, latch `weight_data` into the weight register and go to DECAY.
  - Waits indefinitely for a weight.
- DECAY:
  - Register `decayed_potential` from `potential`.
  - `DECAY_EN`=0: copy unchanged.
  - `DECAY_EN`=1, exponent field [30:23]:
    - 0 or 1: result 32'h00000000 (flush, sign dropped).
    - 255: pass unchanged.
    - Otherwise: exponent−1, sign and mantissa kept.
- APPLY:
  - `input_weight` and `decayed_potential` held stable.
  - 4-bit counter runs `SETTLE_CYCLES` cycles, then CAPTURE.
- CAPTURE:
  - `potential` ← `final_potential`; spike flag ← `spike_in`.
  - Spike flag=1: go to EMIT; else go to CLEAR.
- EMIT: `spike_valid`=1 until `spike_ready`=1 is sampled, then CLEAR. `spike_valid` never drops without a handshake.
- CLEAR:
  - One cycle: `clear_adder`=1 and `done`=1.
  - Then IDLE.
- `input_weight`/`decayed_potential` registers retain their values outside APPLY.
- Overrun: `timestep_start`=1 in any state other than IDLE is ignored. `overrun_count` increments and saturates at 255.
- No FP arithmetic in this block beyond the decay exponent decrement; add/compare/reset are performed by the adder.

## Timing
- Reset values:
  - `potential`=`V_INIT`.
  - `decayed_potential`, `input_weight`=0.
  - `overrun_count`=0.
  - `weight_ready`, `spike_valid`, `clear_adder`, `done`=0.
  - `set_adder`=1 (INIT).
  - `busy`=1 (INIT).
- Reset asserted in any state returns to INIT asynchronously. The pending spike is discarded and `potential` is restored to `V_INIT`.
- Latency counted from the cycle `timestep_start` is sampled, with the weight already valid:
  - No spike: `done` high in cycle 4+`SETTLE_CYCLES` (6 at default).
  - Spike with `spike_ready` held high: `done` high in cycle 5+`SETTLE_CYCLES`.
- `spike_valid` rises the cycle after CAPTURE.
- `timestep_start` coincident with `done`: counted as an overrun, not started.
- `timestep_start` and `weight_valid` in the same cycle: the start is taken; the weight is accepted on the next cycle.
- All outputs are registered except `weight_ready`, `busy`, `set_adder`, `clear_adder`, and `done`, which are decoded directly from the state register.

## Test plan
- Reset release → `set_adder`=1 for exactly one cycle; `potential`=0; `busy` falls one cycle later.
- Weight 0x41F00000 (30.0), threshold 40.0 → no spike; `potential`=0x41F00000; `done` at cycle 6.
- Second weight 0x41F00000 → decayed value 0x41700000 (15.0) presented; sum 45.0 spikes; `potential`=0x40A00000 (5.0); one `spike_valid` event emitted.
- Spike with `spike_ready` held low 10 cycles → `spike_valid` stays high; `done` fires only after the handshake.
- Potential 0x00800000 with `DECAY_EN`=1 → decayed value 0x00000000. `timestep_start` pulsed during APPLY → `overrun_count`=1 and the timestep is unaffected.
- `RST_N` low mid-APPLY → outputs return to reset values immediately; next timestep starts from `V_INIT`.
